// File: rtl/multi_adc_serial_ctrl_if.sv
// Bus-side and pin-side signal bundle for multi_adc_serial_ctrl.
// The slave view belongs to the controller; the master view to the register block/bench.
interface multi_adc_serial_ctrl_if #(
   parameter int NUM_ADC = 2,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 16
);
   logic [NUM_ADC-1:0]        cpu_req;
   logic [NUM_ADC*ADDR_W-1:0] cpu_addr;
   logic [NUM_ADC*DATA_W-1:0] cpu_data;
   logic [NUM_ADC-1:0]        cpu_ack;
   logic [NUM_ADC-1:0]        cfg_done;
   logic [NUM_ADC-1:0]        cfg_idle;
   logic [NUM_ADC-1:0]        auto_busy;
   logic [NUM_ADC-1:0]        auto_restart;
   logic [NUM_ADC-1:0]        adc_reset_req;
   logic [NUM_ADC-1:0]        sclk;
   logic [NUM_ADC-1:0]        sdata;
   logic [NUM_ADC-1:0]        sstrobe_n;
   logic [NUM_ADC-1:0]        adc_reset;
   logic [NUM_ADC-1:0]        dcm_reset;

   modport slave (
      input  cpu_req, cpu_addr, cpu_data, auto_restart, adc_reset_req,
      output cpu_ack, cfg_done, cfg_idle, auto_busy,
      output sclk, sdata, sstrobe_n, adc_reset, dcm_reset
   );

   modport master (
      output cpu_req, cpu_addr, cpu_data, auto_restart, adc_reset_req,
      input  cpu_ack, cfg_done, cfg_idle, auto_busy,
      input  sclk, sdata, sstrobe_n, adc_reset, dcm_reset
   );
endinterface

// File: rtl/multi_adc_serial_ctrl.sv
// N-channel ADC control core: per-channel 3-wire config master, power-up autoconfig
// sequencer, CPU command handshake and DCM reset stretcher, all in the OPB_Clk domain.
module multi_adc_serial_ctrl #(
   parameter int                                   NUM_ADC   = 2,
   parameter int                                   ADDR_W    = 4,
   parameter int                                   DATA_W    = 16,
   parameter int                                   CLK_DIV   = 4,
   parameter int                                   RST_CNT_W = 8,
   parameter logic [NUM_ADC-1:0]                   AUTO_EN   = {NUM_ADC{1'b1}},
   parameter int                                   AUTO_LEN  = 2,
   parameter logic [AUTO_LEN*(ADDR_W+DATA_W)-1:0]  AUTO_TABLE = '0
) (
   input  logic                         OPB_Clk,
   input  logic                         OPB_Rst,
   multi_adc_serial_ctrl_if.slave       bus
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int IDX_W   = (AUTO_LEN > 1) ? $clog2(AUTO_LEN) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LO,
      S_HI,
      S_HOLD
   } state_e;

   function automatic logic [FRAME_W-1:0] auto_entry(input int k);
      return AUTO_TABLE[k*FRAME_W +: FRAME_W];
   endfunction

   // Counts down toward zero and sticks there.
   function automatic logic [RST_CNT_W-1:0] sat_dec(input logic [RST_CNT_W-1:0] v);
      return (v == '0) ? '0 : v - RST_CNT_W'(1);
   endfunction

   logic [NUM_ADC-1:0] ack_v, done_v, idle_v, busy_v;
   logic [NUM_ADC-1:0] sclk_v, sdata_v, strobe_n_v, adc_rst_v, dcm_v;

   for (genvar n = 0; n < NUM_ADC; n++) begin : g_ch
      state_e               st_q, st_d;
      logic [DIV_W-1:0]     div_q, div_d;
      logic [BIT_W-1:0]     bit_q, bit_d;
      logic [FRAME_W-1:0]   frame_q, frame_d;
      logic                 start_q, start_d;
      logic                 auto_busy_q, auto_busy_d;
      logic [IDX_W-1:0]     idx_q, idx_d;
      logic                 ack_q, ack_d;
      logic                 done_q, done_d;
      logic                 sclk_q, sclk_d;
      logic                 sdata_q, sdata_d;
      logic                 strobe_n_q, strobe_n_d;
      logic                 adc_rst_q, adc_rst_d;
      logic [RST_CNT_W-1:0] dcm_q, dcm_d;
      logic                 idle;
      logic                 div_end;

      assign idle    = (st_q == S_IDLE) && !start_q && !auto_busy_q;
      assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

      always_comb begin
         st_d        = st_q;
         div_d       = div_q;
         bit_d       = bit_q;
         frame_d     = frame_q;
         start_d     = start_q;
         auto_busy_d = auto_busy_q;
         idx_d       = idx_q;
         ack_d       = 1'b0;
         done_d      = 1'b0;

         case (st_q)
            S_IDLE: begin
               // Priority: running autoconfig, then a latched CPU word, then new requests;
               // a restart beats a coincident CPU request, which simply stays pending.
               if (auto_busy_q) begin
                  frame_d = auto_entry(int'(idx_q));
                  st_d    = S_SETUP;
                  div_d   = '0;
               end else if (start_q) begin
                  start_d = 1'b0;
                  st_d    = S_SETUP;
                  div_d   = '0;
               end else if (bus.auto_restart[n] && AUTO_EN[n]) begin
                  auto_busy_d = 1'b1;
                  idx_d       = '0;
               end else if (bus.cpu_req[n]) begin
                  ack_d   = 1'b1;
                  start_d = 1'b1;
                  frame_d = {bus.cpu_addr[n*ADDR_W +: ADDR_W], bus.cpu_data[n*DATA_W +: DATA_W]};
               end
            end
            S_SETUP: begin
               div_d = div_q + DIV_W'(1);
               if (div_end) begin
                  st_d  = S_LO;
                  div_d = '0;
                  bit_d = BIT_W'(FRAME_W - 1);
               end
            end
            S_LO: begin
               div_d = div_q + DIV_W'(1);
               if (div_end) begin
                  st_d  = S_HI;
                  div_d = '0;
               end
            end
            S_HI: begin
               div_d = div_q + DIV_W'(1);
               if (div_end) begin
                  div_d   = '0;
                  frame_d = {frame_q[FRAME_W-2:0], 1'b0};
                  if (bit_q == '0) begin
                     st_d = S_HOLD;
                  end else begin
                     st_d  = S_LO;
                     bit_d = bit_q - BIT_W'(1);
                  end
               end
            end
            S_HOLD: begin
               div_d = div_q + DIV_W'(1);
               if (div_end) begin
                  st_d   = S_IDLE;
                  div_d  = '0;
                  done_d = 1'b1;
                  if (auto_busy_q) begin
                     if (idx_q == IDX_W'(AUTO_LEN - 1)) auto_busy_d = 1'b0;
                     else                               idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               st_d  = S_IDLE;
               div_d = '0;
            end
         endcase

         // Pins are registered copies of the next state so they switch cleanly with it.
         sclk_d     = (st_d == S_HI);
         strobe_n_d = (st_d == S_IDLE);
         sdata_d    = (st_d != S_IDLE) && frame_d[FRAME_W-1];
         adc_rst_d  = bus.adc_reset_req[n];
         dcm_d      = (bus.adc_reset_req[n] || auto_busy_q) ? '1 : sat_dec(dcm_q);
      end

      always_ff @(posedge OPB_Clk) begin
         if (OPB_Rst) begin
            st_q        <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            start_q     <= 1'b0;
            auto_busy_q <= AUTO_EN[n];
            idx_q       <= '0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            strobe_n_q  <= 1'b1;
            adc_rst_q   <= 1'b1;
            dcm_q       <= '1;
         end else begin
            st_q        <= st_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            start_q     <= start_d;
            auto_busy_q <= auto_busy_d;
            idx_q       <= idx_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            strobe_n_q  <= strobe_n_d;
            adc_rst_q   <= adc_rst_d;
            dcm_q       <= dcm_d;
         end
      end

      // Shift data needs no reset: it is always loaded before a frame starts.
      always_ff @(posedge OPB_Clk) begin
         frame_q <= frame_d;
      end

      assign ack_v[n]      = ack_q;
      assign done_v[n]     = done_q;
      assign idle_v[n]     = idle;
      assign busy_v[n]     = auto_busy_q;
      assign sclk_v[n]     = sclk_q;
      assign sdata_v[n]    = sdata_q;
      assign strobe_n_v[n] = strobe_n_q;
      assign adc_rst_v[n]  = adc_rst_q;
      assign dcm_v[n]      = (dcm_q != '0);
   end

   assign bus.cpu_ack   = ack_v;
   assign bus.cfg_done  = done_v;
   assign bus.cfg_idle  = idle_v;
   assign bus.auto_busy = busy_v;
   assign bus.sclk      = sclk_v;
   assign bus.sdata     = sdata_v;
   assign bus.sstrobe_n = strobe_n_v;
   assign bus.adc_reset = adc_rst_v;
   assign bus.dcm_reset = dcm_v;

endmodule

// File: tb/tb_multi_adc_serial_ctrl.sv
// Directed bench for multi_adc_serial_ctrl: autoconfig, CPU frames, reset abort,
// restart arbitration and the ADC/DCM reset path on a two-channel instance.
module tb_multi_adc_serial_ctrl;

   localparam logic [39:0] TABLE = {20'h1_00FF, 20'h2_8001};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_adc_serial_ctrl_if #(.NUM_ADC(2), .ADDR_W(4), .DATA_W(16)) bus ();

   multi_adc_serial_ctrl #(
      .NUM_ADC(2), .ADDR_W(4), .DATA_W(16), .CLK_DIV(2), .RST_CNT_W(8),
      .AUTO_EN(2'b11), .AUTO_LEN(2), .AUTO_TABLE(TABLE)
   ) dut (
      .OPB_Clk(clk),
      .OPB_Rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [19:0] val;
      int          len;
      int          edges;
      logic        done;
      int          fall;
   } frm_t;

   frm_t q0[$];
   frm_t q1[$];

   // Pin-level frame decoder: shifts sdata on each sclk rise while the strobe is low.
   initial begin
      logic [19:0] sh [2];
      int          len [2];
      int          edg [2];
      int          fall [2];
      logic        psclk [2];
      frm_t        r;
      for (int c = 0; c < 2; c++) begin
         sh[c] = '0; len[c] = 0; edg[c] = 0; fall[c] = 0; psclk[c] = 1'b0;
      end
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
               if (bus.sstrobe_n[c] === 1'b0) begin
                  if (len[c] == 0) fall[c] = cyc;
                  len[c]++;
                  if (bus.sclk[c] === 1'b1 && psclk[c] === 1'b0) begin
                     sh[c] = {sh[c][18:0], bus.sdata[c]};
                     edg[c]++;
                  end
               end else if (len[c] != 0) begin
                  r.val = sh[c]; r.len = len[c]; r.edges = edg[c];
                  r.done = bus.cfg_done[c]; r.fall = fall[c];
                  if (c == 0) q0.push_back(r);
                  else        q1.push_back(r);
                  sh[c] = '0; len[c] = 0; edg[c] = 0;
               end
               psclk[c] = bus.sclk[c];
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic take(input int c, output frm_t r);
      r.val = '0; r.len = 0; r.edges = 0; r.done = 1'b0; r.fall = -1;
      if (c == 0) begin
         if (q0.size() > 0) r = q0.pop_front();
      end else begin
         if (q1.size() > 0) r = q1.pop_front();
      end
   endtask

   task automatic chk_frame(input string tag, input int c, input logic [19:0] val, output int fall);
      frm_t r;
      take(c, r);
      chk({tag, "_val"},   32'(r.val),   32'(val));
      chk({tag, "_len"},   32'(r.len),   32'd84);
      chk({tag, "_edges"}, 32'(r.edges), 32'd20);
      chk({tag, "_done"},  32'(r.done),  32'd1);
      fall = r.fall;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_strobe"},  32'(bus.sstrobe_n), 32'h3);
      chk({tag, "_sclk"},    32'(bus.sclk),      32'h0);
      chk({tag, "_sdata"},   32'(bus.sdata),     32'h0);
      chk({tag, "_ack"},     32'(bus.cpu_ack),   32'h0);
      chk({tag, "_done"},    32'(bus.cfg_done),  32'h0);
      chk({tag, "_busy"},    32'(bus.auto_busy), 32'h3);
      chk({tag, "_idle"},    32'(bus.cfg_idle),  32'h0);
      chk({tag, "_adcrst"},  32'(bus.adc_reset), 32'h3);
      chk({tag, "_dcm"},     32'(bus.dcm_reset), 32'h3);
   endtask

   initial begin
      int n;
      int t;
      int s;
      int early;
      int f0;
      int f1;
      int viol;
      frm_t r;

      bus.cpu_req = '0; bus.cpu_addr = '0; bus.cpu_data = '0;
      bus.auto_restart = '0; bus.adc_reset_req = '0;
      repeat (3) step();
      mon_en = 1'b1;
      chk_reset_state("rst");

      // Autoconfig on both channels, with a CPU request for channel 0 parked behind it.
      rst = 1'b0;
      bus.cpu_req = 2'b01; bus.cpu_addr = 8'h05; bus.cpu_data = 32'h0000_BEEF;
      n = 0; early = 0;
      while (bus.auto_busy !== 2'b00 && n < 600) begin
         step(); n++;
         if (bus.auto_busy !== 2'b00 && bus.cpu_ack !== 2'b00) early++;
      end
      chk("s1_busy_timeout", 32'(n < 600), 32'd1);
      chk("s3_no_early_ack", 32'(early), 32'd0);
      chk("s1_done_w_busy", 32'(bus.cfg_done), 32'h3);
      t = cyc;
      step();
      chk("s3_ack", 32'(bus.cpu_ack), 32'h1);
      bus.cpu_req = 2'b00;
      while (cyc < t + 254) step();
      chk("s1_dcm_hold", 32'(bus.dcm_reset), 32'h3);
      step();
      chk("s1_dcm_fall", 32'(bus.dcm_reset), 32'h0);
      chk("s1_q1_count", 32'(q1.size()), 32'd2);
      chk("s1_q0_count", 32'(q0.size()), 32'd3);
      chk_frame("s1_c1_e0", 1, 20'h2_8001, f0);
      chk_frame("s1_c1_e1", 1, 20'h1_00FF, f1);
      chk("s1_c1_gap", 32'(f1 - f0), 32'd85);
      chk_frame("s1_c0_e0", 0, 20'h2_8001, f0);
      chk_frame("s1_c0_e1", 0, 20'h1_00FF, f1);
      chk_frame("s3_c0_cpu", 0, 20'h5_BEEF, f0);
      chk("s3_cpu_start", 32'(f0), 32'(t + 2));

      // Single CPU write on channel 1; channel 0 must stay quiet.
      step();
      s = cyc;
      bus.cpu_req = 2'b10; bus.cpu_addr = 8'hA0; bus.cpu_data = 32'h1234_0000;
      chk("s2_ack_pre", 32'(bus.cpu_ack), 32'h0);
      step();
      chk("s2_ack", 32'(bus.cpu_ack), 32'h2);
      bus.cpu_req = 2'b00;
      n = 0;
      while (bus.cfg_done[1] !== 1'b1 && n < 200) begin step(); n++; end
      chk("s2_done_cycle", 32'(cyc), 32'(s + 86));
      step();
      chk_frame("s2_c1_cpu", 1, 20'hA_1234, f0);
      chk("s2_c0_quiet", 32'(q0.size()), 32'd0);
      chk("s2_idle", 32'(bus.cfg_idle), 32'h3);

      // ADC reset request on channel 1 only.
      s = cyc;
      bus.adc_reset_req = 2'b10;
      viol = 0;
      for (int i = 1; i <= 260; i++) begin
         step();
         if (i == 3) bus.adc_reset_req = 2'b00;
         if (bus.adc_reset[0] !== 1'b0 || bus.dcm_reset[0] !== 1'b0) viol++;
         if (i <= 4) chk($sformatf("s6_adcrst_%0d", i), 32'(bus.adc_reset[1]), 32'(i <= 3));
         if (i == 1)   chk("s6_dcm_rise", 32'(bus.dcm_reset[1]), 32'd1);
         if (i == 257) chk("s6_dcm_hold", 32'(bus.dcm_reset[1]), 32'd1);
         if (i == 258) chk("s6_dcm_fall", 32'(bus.dcm_reset[1]), 32'd0);
      end
      chk("s6_c0_untouched", 32'(viol), 32'd0);

      // Restart and CPU request in the same idle cycle; restart pulses mid-frame are ignored.
      bus.auto_restart = 2'b01; bus.cpu_req = 2'b01;
      bus.cpu_addr = 8'h03; bus.cpu_data = 32'h0000_0F0F;
      step();
      bus.auto_restart = 2'b00;
      chk("s5_busy", 32'(bus.auto_busy), 32'h1);
      chk("s5_no_ack", 32'(bus.cpu_ack), 32'h0);
      repeat (30) step();
      bus.auto_restart = 2'b01;
      step();
      bus.auto_restart = 2'b00;
      n = 0; early = 0;
      while (bus.auto_busy[0] !== 1'b0 && n < 600) begin
         step(); n++;
         if (bus.auto_busy[0] === 1'b1 && bus.cpu_ack[0] !== 1'b0) early++;
      end
      chk("s5_busy_timeout", 32'(n < 600), 32'd1);
      chk("s5_no_early_ack", 32'(early), 32'd0);
      step();
      chk("s5_ack", 32'(bus.cpu_ack), 32'h1);
      bus.cpu_req = 2'b00;
      repeat (20) step();
      bus.auto_restart = 2'b01;
      step();
      bus.auto_restart = 2'b00;
      n = 0;
      while (bus.cfg_done[0] !== 1'b1 && n < 200) begin step(); n++; end
      repeat (5) step();
      chk("s5_busy_after", 32'(bus.auto_busy[0]), 32'd0);
      chk("s5_idle_after", 32'(bus.cfg_idle[0]), 32'd1);
      chk("s5_q0_count", 32'(q0.size()), 32'd3);
      chk_frame("s5_e0", 0, 20'h2_8001, f0);
      chk_frame("s5_e1", 0, 20'h1_00FF, f1);
      chk_frame("s5_cpu", 0, 20'h3_0F0F, f0);

      // Reset in the low phase of bit 10 of a channel-1 CPU frame.
      step();
      s = cyc;
      bus.cpu_req = 2'b10; bus.cpu_addr = 8'h70; bus.cpu_data = 32'h5555_0000;
      step();
      chk("s4_ack", 32'(bus.cpu_ack), 32'h2);
      bus.cpu_req = 2'b00;
      while (cyc < s + 40) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_state("s4_rst");
      n = 0;
      while (bus.auto_busy !== 2'b00 && n < 600) begin step(); n++; end
      chk("s4_busy_timeout", 32'(n < 600), 32'd1);
      step();
      take(1, r);
      chk("s4_abort_done", 32'(r.done), 32'd0);
      chk("s4_abort_len", 32'(r.len), 32'd39);
      chk("s4_abort_edges", 32'(r.edges), 32'd9);
      chk_frame("s4_c1_e0", 1, 20'h2_8001, f0);
      chk_frame("s4_c1_e1", 1, 20'h1_00FF, f1);
      chk_frame("s4_c0_e0", 0, 20'h2_8001, f0);
      chk_frame("s4_c0_e1", 0, 20'h1_00FF, f1);
      chk("s4_q_empty", 32'(q0.size() + q1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_adc_serial_ctrl.md
Name: multi_adc_serial_ctrl

Overview:
- Parametrised N-channel ADC control core. Each ADC gets its own 3-wire serial configuration master, a power-up autoconfig sequencer, CPU command arbitration, and a DCM reset stretcher.
- Generalises the fixed two-ADC, 4-bit-address/16-bit-data controller: channel count, word widths, serial clock rate, reset stretch length and the autoconfig table are all parameters.
- Adds a per-channel command handshake and an autoconfig re-run.
- Sits between the bus-attach register block and the ADC mezzanine pins, in the OPB_Clk domain.

Parameters:
- NUM_ADC, 2, number of independent ADC channels (1..8).
- ADDR_W, 4, serial register address width.
- DATA_W, 16, serial register data width; FRAME_W = ADDR_W+DATA_W.
- CLK_DIV, 4, OPB_Clk cycles per serial clock half-period (>=1).
- RST_CNT_W, 8, DCM reset stretch counter width.
- AUTO_EN, {NUM_ADC{1'b1}}, per-channel autoconfig enable mask.
- AUTO_LEN, 2, number of autoconfig words (>=1).
- AUTO_TABLE, 0, AUTO_LEN*FRAME_W bits, shared by all channels. Entry k = bits [k*FRAME_W +: FRAME_W], formatted {addr,data}.

Ports:
- OPB_Clk in 1: the block's single clock.
- OPB_Rst in 1: reset; synchronous, active-high.
- cpu_req in NUM_ADC: per-channel write request; held high until acked.
- cpu_addr in NUM_ADC*ADDR_W: channel n at [n*ADDR_W +: ADDR_W].
- cpu_data in NUM_ADC*DATA_W: channel n at [n*DATA_W +: DATA_W].
- cpu_ack out NUM_ADC: 1-cycle pulse when a request is latched.
- cfg_done out NUM_ADC: 1-cycle pulse at the end of every frame (CPU or auto).
- cfg_idle out NUM_ADC: serial engine idle and not auto-busy.
- auto_busy out NUM_ADC: autoconfig sequence in progress.
- auto_restart in NUM_ADC: pulse to re-run autoconfig.
- adc_reset_req in NUM_ADC: ADC/DCM reset request from the register block.
- sclk out NUM_ADC: 3-wire clock, idle low.
- sdata out NUM_ADC: 3-wire data, MSB first; address, then data.
- sstrobe_n out NUM_ADC: active-low frame strobe, idle high.
- adc_reset out NUM_ADC: registered adc_reset_req (IOB flop).
- dcm_reset out NUM_ADC: stretched DCM reset.

Behaviour:

Reset (OPB_Rst high for one edge):
- sclk=0, sdata=0, sstrobe_n=1, cpu_ack=0, cfg_done=0.
- adc_reset=all-ones, dcm counters=all-ones.
- auto_busy[n]=AUTO_EN[n]; autoconfig index=0.
- cfg_idle=~AUTO_EN.
- Reset mid-frame aborts the frame: strobe high on the next cycle, no cfg_done, pending request dropped.

Serial engine states (per channel): IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- SETUP: CLK_DIV cycles; sstrobe_n=0, sclk=0, sdata=frame MSB.
- SHIFT, per bit i = FRAME_W-1..0: low phase CLK_DIV cycles (sclk=0, sdata=bit i), then high phase CLK_DIV cycles (sclk=1, sdata held).
- HOLD: CLK_DIV cycles; sclk=0, sstrobe_n=0.
- Return to IDLE: sstrobe_n=1, with cfg_done pulsed in the same cycle.
- Frame length from leaving IDLE: (2*FRAME_W+2)*CLK_DIV cycles.
- The engine re-enters a frame no earlier than 1 cycle after IDLE.

Frame sources:
- While auto_busy=1, only the autoconfig sequencer may start frames. It issues entries 0..AUTO_LEN-1 in order, each starting the cycle after the previous cfg_done.
- auto_busy falls in the cycle of the final entry's cfg_done.
- CPU: when cfg_idle=1 and cpu_req=1, latch addr/data, pulse cpu_ack, and start the frame next cycle.
- A request arriving during auto_busy or an active frame waits; no ack and no loss.
- auto_restart while cfg_idle: auto_busy=1 the next cycle and the sequence restarts at index 0.
- auto_restart while auto_busy or mid-frame: ignored.
- auto_restart and cpu_req asserted in the same idle cycle: autoconfig wins; cpu_req stays pending.
- AUTO_EN[n]=0: auto_restart[n] is ignored and auto_busy[n] stays 0.

DCM and ADC reset:
- adc_reset <= adc_reset_req, one-cycle latency.
- dcm counter: loaded to all-ones while adc_reset_req or auto_busy is high; otherwise decrements toward 0 and saturates there.
- dcm_reset = (counter != 0).
- Channels are fully independent; no cross-channel arbitration.

Test Plan (NUM_ADC=2, ADDR_W=4, DATA_W=16, CLK_DIV=2, AUTO_LEN=2, AUTO_TABLE={20'h1_00FF, 20'h2_8001}):
1. Release reset -> both channels frame entry0 (addr 2, data 8001), then entry1 (addr 1, data 00FF).
   - Each frame is 84 cycles of strobe low with 20 rising sclk edges.
   - Sampled bits equal the table entry, MSB first.
   - auto_busy falls with the second cfg_done.
   - dcm_reset falls exactly 255 cycles later.
2. After autoconfig, cpu_req[1] with addr=4'hA, data=16'h1234 -> cpu_ack[1] next cycle.
   - Channel 1 shifts 20'hA1234; cfg_done[1] after 84 cycles.
   - Channel 0 pins remain idle throughout.
3. cpu_req[0] asserted during autoconfig -> no ack until auto_busy[0] falls, then ack.
   - The CPU frame follows the autoconfig frames; nothing is lost.
4. Assert OPB_Rst at bit 10 of a CPU frame -> sstrobe_n=1 next cycle, no cfg_done, autoconfig restarts after reset.
5. auto_restart[0] while idle, coincident with cpu_req[0] -> autoconfig runs first, then the CPU frame.
   - auto_restart pulsed mid-frame -> ignored.
6. adc_reset_req[1] held high for 3 cycles -> adc_reset[1] is high for 3 cycles, delayed by 1.
   - dcm_reset[1] falls 255 cycles after the request drops.
   - Channel 0 is unaffected.
